// File: rtl/serial_data_packer.sv
// Serial-to-parallel word packer: LSB-first chunks assembled into a word and handed off through a one-deep holding register.
// Optional drop counter port (drop_count_o) is enabled by defining SERIAL_PACKER_DROP_CNT_EN.
module serial_data_packer #(
  parameter int ROM_DATA_WIDTH = 96,
  parameter int SELECT_SIZE    = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [SELECT_SIZE-1:0]    serial_data_i,
  input  logic                      serial_valid_i,
  input  logic                      frame_start_i,
  output logic [ROM_DATA_WIDTH-1:0] word_data_o,
  output logic                      word_valid_o,
  input  logic                      word_ready_i,
`ifdef SERIAL_PACKER_DROP_CNT_EN
  output logic                      overflow_o,
  output logic [7:0]                drop_count_o
`else
  output logic                      overflow_o
`endif
);

  localparam int CHUNKS = ROM_DATA_WIDTH / SELECT_SIZE;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHUNKS - 1);

  generate
    if (ROM_DATA_WIDTH % SELECT_SIZE != 0) begin : g_bad_width
      $error("serial_data_packer: ROM_DATA_WIDTH must be a multiple of SELECT_SIZE");
    end
  endgenerate

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // New chunk enters at the top so that after CHUNKS shifts chunk k sits at [k*S+S-1:k*S].
  function automatic logic [ROM_DATA_WIDTH-1:0] shift_in(
    input logic [ROM_DATA_WIDTH-1:0] base,
    input logic [SELECT_SIZE-1:0]    chunk
  );
    logic [ROM_DATA_WIDTH-1:0] r;
    r = base >> SELECT_SIZE;
    r[ROM_DATA_WIDTH-1 -: SELECT_SIZE] = chunk;
    return r;
  endfunction

  logic [CNT_W-1:0]          cnt_p0;
  logic [ROM_DATA_WIDTH-1:0] asm_p0;
  state_t                    state_p1;

  logic                      start_p0;
  logic [CNT_W-1:0]          idx_p0;
  logic [CNT_W-1:0]          cnt_next_p0;
  logic [ROM_DATA_WIDTH-1:0] asm_next_p0;
  logic                      vld_p0;
  logic                      drop_p0;

  // ---- stage p0: chunk assembly ----
  always_comb begin
    start_p0    = serial_valid_i & frame_start_i;
    idx_p0      = start_p0 ? '0 : cnt_p0;
    asm_next_p0 = shift_in(start_p0 ? '0 : asm_p0, serial_data_i);
    vld_p0      = serial_valid_i && (idx_p0 == LAST_IDX);
    cnt_next_p0 = vld_p0 ? '0 : idx_p0 + 1'b1;
    drop_p0     = vld_p0 && (state_p1 == FULL) && !word_ready_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_p0 <= '0;
      asm_p0 <= '0;
    end else if (serial_valid_i) begin
      cnt_p0 <= cnt_next_p0;
      asm_p0 <= asm_next_p0;
    end
  end

  // ---- stage p1: output holding register ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_p1    <= EMPTY;
      word_data_o <= '0;
      overflow_o  <= 1'b0;
    end else begin
      overflow_o <= 1'b0;
      case (state_p1)
        EMPTY: begin
          if (vld_p0) begin
            word_data_o <= asm_next_p0;
            state_p1    <= FULL;
          end
        end
        FULL: begin
          if (vld_p0) begin
            if (word_ready_i) word_data_o <= asm_next_p0;
            else              overflow_o  <= 1'b1;
          end else if (word_ready_i) begin
            state_p1 <= EMPTY;
          end
        end
        default: state_p1 <= EMPTY;
      endcase
    end
  end

  assign word_valid_o = (state_p1 == FULL);

`ifdef SERIAL_PACKER_DROP_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      drop_count_o <= 8'd0;
    else if (drop_p0 && (drop_count_o != 8'hFF))
      drop_count_o <= drop_count_o + 8'd1;
  end
`else
  logic unused_drop_p0;
  assign unused_drop_p0 = drop_p0;
`endif

endmodule

// File: tb/tb_serial_data_packer.sv
// Directed self-checking bench for serial_data_packer (W=96, S=3) with hand-computed expected words.
module tb_serial_data_packer;

  localparam int W = 96;
  localparam int S = 3;

  localparam logic [W-1:0] WORD_5 = 96'hB6DB6DB6DB6DB6DB6DB6DB6D;
  localparam logic [W-1:0] WORD_2 = 96'h492492492492492492492492;
  localparam logic [W-1:0] WORD_3 = 96'h6DB6DB6DB6DB6DB6DB6DB6DB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [S-1:0] serial_data = '0;
  logic         serial_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic [W-1:0] word_data;
  logic         word_valid;
  logic         word_ready = 1'b0;
  logic         overflow;
`ifdef SERIAL_PACKER_DROP_CNT_EN
  logic [7:0]   drop_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_data_packer #(.ROM_DATA_WIDTH(W), .SELECT_SIZE(S)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .serial_data_i  (serial_data),
    .serial_valid_i (serial_valid),
    .frame_start_i  (frame_start),
    .word_data_o    (word_data),
    .word_valid_o   (word_valid),
    .word_ready_i   (word_ready),
`ifdef SERIAL_PACKER_DROP_CNT_EN
    .overflow_o     (overflow),
    .drop_count_o   (drop_count)
`else
    .overflow_o     (overflow)
`endif
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [S-1:0] d, input logic fs);
    serial_data  = d;
    serial_valid = 1'b1;
    frame_start  = fs;
    @(posedge clk); #1;
    serial_valid = 1'b0;
    frame_start  = 1'b0;
  endtask

  task automatic send_n(input logic [S-1:0] d, input int n);
    for (int i = 0; i < n; i++) send(d, 1'b0);
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", W'(word_valid), W'(0));
    chk("rst_data", word_data, '0);
    chk("rst_ovf", W'(overflow), W'(0));
    #2 rst = 1'b0;
    idle();

    // 32 chunks of 101, consumer ready
    word_ready = 1'b1;
    send_n(3'b101, 31);
    chk("w5_not_yet", W'(word_valid), W'(0));
    send(3'b101, 1'b0);
    chk("w5_valid", W'(word_valid), W'(1));
    chk("w5_data", word_data, WORD_5);
    idle();
    chk("w5_consumed", W'(word_valid), W'(0));
    chk("w5_retained", word_data, WORD_5);

    // single-chunk patterns at both ends of the word
    send(3'b001, 1'b0);
    send_n(3'b000, 31);
    chk("lsb_valid", W'(word_valid), W'(1));
    chk("lsb_data", word_data, 96'h1);
    send_n(3'b000, 31);
    send(3'b100, 1'b0);
    chk("msb_data", word_data, 96'h800000000000000000000000);
    idle();

    // two words with no consumer: second dropped
    word_ready = 1'b0;
    send_n(3'b101, 32);
    chk("hold_valid", W'(word_valid), W'(1));
    chk("hold_data", word_data, WORD_5);
    send_n(3'b010, 31);
    chk("hold_no_ovf", W'(overflow), W'(0));
    send(3'b010, 1'b0);
    chk("drop_ovf", W'(overflow), W'(1));
    chk("drop_keep", word_data, WORD_5);
    chk("drop_valid", W'(word_valid), W'(1));
    idle();
    chk("ovf_one_cycle", W'(overflow), W'(0));
`ifdef SERIAL_PACKER_DROP_CNT_EN
    chk("drop_count", W'(drop_count), W'(1));
`endif
    word_ready = 1'b1;
    idle();
    chk("drain_valid", W'(word_valid), W'(0));

    // consume and complete in the same cycle
    word_ready = 1'b0;
    send_n(3'b101, 32);
    send_n(3'b010, 31);
    word_ready = 1'b1;
    send(3'b010, 1'b0);
    chk("swap_valid", W'(word_valid), W'(1));
    chk("swap_data", word_data, WORD_2);
    chk("swap_no_ovf", W'(overflow), W'(0));
    idle();
    chk("swap_drain", W'(word_valid), W'(0));

    // frame_start discards a partial word
    send_n(3'b111, 10);
    send(3'b001, 1'b1);
    send_n(3'b000, 22);
    chk("fs_no_early", W'(word_valid), W'(0));
    send_n(3'b000, 8);
    chk("fs_not_yet", W'(word_valid), W'(0));
    send(3'b000, 1'b0);
    chk("fs_valid", W'(word_valid), W'(1));
    chk("fs_data", word_data, 96'h1);
    idle();

    // asynchronous reset mid-word with a held word
    word_ready = 1'b0;
    send_n(3'b101, 32);
    send_n(3'b111, 20);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", W'(word_valid), W'(0));
    chk("arst_data", word_data, '0);
    chk("arst_ovf", W'(overflow), W'(0));
    @(posedge clk); #3;
    rst = 1'b0;
    word_ready = 1'b1;
    send_n(3'b011, 12);
    chk("arst_no_stale", W'(word_valid), W'(0));
    send_n(3'b011, 19);
    chk("arst_not_yet", W'(word_valid), W'(0));
    send(3'b011, 1'b0);
    chk("arst_valid_new", W'(word_valid), W'(1));
    chk("arst_data_new", word_data, WORD_3);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_data_packer.md
SERIAL_DATA_PACKER -- requirements
Module: serial_data_packer

Interface
REQ-001 Parameter ROM_DATA_WIDTH, default 96, width of the assembled word in bits.
REQ-002 Parameter SELECT_SIZE, default 3, width of one serial chunk in bits.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 serial_data_i  input  SELECT_SIZE  serial chunk, LSB chunk of the word first.
REQ-006 serial_valid_i  input  1  chunk on serial_data_i is sampled this cycle when high.
REQ-007 frame_start_i  input  1  qualified by serial_valid_i; marks the current chunk as chunk 0 of a new word.
REQ-008 word_data_o  output  ROM_DATA_WIDTH  assembled word held in the output register.
REQ-009 word_valid_o  output  1  word_data_o holds an unconsumed word.
REQ-010 word_ready_i  input  1  consumer accepts word_data_o when both word_ready_i and word_valid_o are high.
REQ-011 overflow_o  output  1  one-cycle pulse when a completed word is dropped.

Function
REQ-012 CHUNKS = ROM_DATA_WIDTH/SELECT_SIZE; ROM_DATA_WIDTH SHALL be an integer multiple of SELECT_SIZE, and elaboration SHALL fail otherwise.
REQ-013 Chunk counter cnt SHALL run 0..CHUNKS-1 and SHALL be sized with $clog2(CHUNKS) bits, minimum 1.
REQ-014 On an accepted chunk, the assembly register SHALL shift right by SELECT_SIZE with serial_data_i inserted at bits [W-1:W-SELECT_SIZE], so chunk k lands at bits [k*S+S-1:k*S].
REQ-015 On an accepted chunk with frame_start_i high, the partial word SHALL be discarded, the chunk SHALL count as chunk 0, and cnt SHALL become 1.
REQ-016 The chunk accepted at cnt==CHUNKS-1 SHALL complete the word, and cnt SHALL wrap to 0.
REQ-017 The output holding register is a 2-state FSM: EMPTY (word_valid_o=0) and FULL (word_valid_o=1).
REQ-018 EMPTY + word complete -> FULL; word_data_o is loaded with the completed word, and both SHALL be visible on the cycle after the last chunk's edge (1-cycle latency).
REQ-019 FULL + word_ready_i + no completion -> EMPTY; word_data_o SHALL retain its value.
REQ-020 FULL + word_ready_i + completion in the same cycle -> remain FULL with the new word loaded; no overflow.
REQ-021 FULL + no word_ready_i + completion -> remain FULL with the old word kept; the new word SHALL be dropped, and overflow_o SHALL be 1 for exactly the next cycle.
REQ-022 Chunk acceptance SHALL never stall; serial_valid_i may be high every cycle or gapped arbitrarily.
REQ-023 word_data_o SHALL remain stable while word_valid_o is high and word_ready_i is low.

Reset
REQ-024 rst_i high SHALL immediately force cnt=0, assembly register=0, word_data_o=0, word_valid_o=0, overflow_o=0 (and drop_count_o=0 when present).
REQ-025 Reset mid-word SHALL discard the partial word; the first accepted chunk after release is chunk 0.

Configuration
REQ-026 Macro SERIAL_PACKER_DROP_CNT_EN defined: an additional port drop_count_o (output, 8 bits) SHALL count dropped words, saturating at 255.
REQ-027 With SERIAL_PACKER_DROP_CNT_EN undefined, the drop_count_o port and counter SHALL be absent; all other behaviour is identical.

Verification (W=96, S=3)
REQ-028 Scenario: 32 consecutive chunks of 3'b101, word_ready_i=1 -> word_valid_o high for 1 cycle, word_data_o=96'hB6DB6DB6DB6DB6DB6DB6DB6D.
REQ-029 Scenario: chunk0=3'b001, chunks1..31=0 -> word_data_o=96'h1; then chunk31=3'b100, all others 0 -> word_data_o=96'h800000000000000000000000.
REQ-030 Scenario: two full words, word_ready_i=0 -> first word held, overflow_o pulses once after the 64th chunk, drop_count_o=1 (macro on).
REQ-031 Scenario: FULL, with word_ready_i=1 in the same cycle as a completing chunk -> new word loaded, word_valid_o stays 1, overflow_o=0.
REQ-032 Scenario: 10 chunks, then a chunk with frame_start_i=1 -> no word until 31 further chunks (32 counted from the frame_start chunk).
REQ-033 Scenario: rst_i asserted asynchronously after 20 chunks -> outputs 0 before the next edge; a word completes only after 32 new chunks.
